// File: rtl/tlb_op_ctrl.sv
// tlb_op_ctrl: multi-cycle TLBP/TLBR/TLBWI/TLBWR sequencer over a single TLB array port.
// Define TLBP_EARLY_EXIT_EN to end a TLBP probe on its first match instead of a full scan.
module tlb_op_ctrl #(
    parameter int TLB_LINE  = 16,
    parameter int TLB_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 op_valid_i,
    input  logic [1:0]           op_i,
    input  logic                 flush_i,
    output logic                 op_ready_o,
    output logic                 stall_o,
    output logic                 done_o,
    input  logic [31:0]          cp0_index_i,
    input  logic [31:0]          cp0_random_i,
    input  logic [31:0]          cp0_entryhi_i,
    input  logic [31:0]          cp0_pagemask_i,
    input  logic [31:0]          cp0_entrylo0_i,
    input  logic [31:0]          cp0_entrylo1_i,
    output logic [TLB_WIDTH-1:0] tlb_addr_o,
    input  logic [127:0]         tlb_rdata_i,
    output logic                 tlb_we_o,
    output logic [127:0]         tlb_wdata_o,
    output logic [3:0]           tlbcmd_o,
    output logic [31:0]          index_o,
    output logic [31:0]          entryhi_o,
    output logic [31:0]          pagemask_o,
    output logic [31:0]          entrylo0_o,
    output logic [31:0]          entrylo1_o
);
    typedef enum logic [2:0] {IDLE, PROBE, READ, WRITE, RESP} state_t;

    state_t               state_q, state_d;
    logic [1:0]           op_q, op_d;
    logic [TLB_WIDTH-1:0] cnt_q, cnt_d, idx_q, idx_d;
    logic                 hit_q, hit_d;
    logic [31:0]          index_q, index_d;
    logic [127:0]         entry_q, entry_d;
    logic [31:0]          e_hi, e_pm, e_lo0, e_lo1;
    logic                 match, last, probe_end;
    logic [TLB_WIDTH-1:0] fidx;
    logic                 unused;

    assign {e_hi, e_pm, e_lo0, e_lo1} = tlb_rdata_i;
    assign match = (((e_hi[31:13] ^ cp0_entryhi_i[31:13]) & ~{3'b0, e_pm[28:13]}) == 19'd0)
                   && ((e_lo0[0] & e_lo1[0]) || e_hi[7:0] == cp0_entryhi_i[7:0]);
    assign last  = cnt_q == TLB_WIDTH'(TLB_LINE - 1);
    assign fidx  = hit_q ? idx_q : cnt_q;
`ifdef TLBP_EARLY_EXIT_EN
    assign probe_end = last | match;
`else
    assign probe_end = last;
`endif
    assign unused = ^{cp0_index_i[31:TLB_WIDTH], cp0_random_i[31:TLB_WIDTH], cp0_entryhi_i[12:8]};

    assign index_o = index_q;
    assign {entryhi_o, pagemask_o, entrylo0_o, entrylo1_o} = entry_q;

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        hit_d       = hit_q;
        index_d     = index_q;
        entry_d     = entry_q;
        op_ready_o  = 1'b0;
        stall_o     = 1'b0;
        done_o      = 1'b0;
        tlb_addr_o  = '0;
        tlb_we_o    = 1'b0;
        tlb_wdata_o = '0;
        tlbcmd_o    = 4'b0;
        case (state_q)
            IDLE: begin
                op_ready_o = 1'b1;
                stall_o    = op_valid_i;
                if (op_valid_i && !flush_i) begin
                    op_d    = op_i;
                    cnt_d   = '0;
                    hit_d   = 1'b0;
                    state_d = op_i == 2'd0 ? PROBE : op_i == 2'd1 ? READ : WRITE;
                end
            end
            PROBE: begin
                stall_o    = 1'b1;
                tlb_addr_o = cnt_q;
                if (flush_i) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (match && !hit_q) begin
                        hit_d = 1'b1;
                        idx_d = cnt_q;
                    end
                    if (probe_end) begin
                        state_d = RESP;
                        cnt_d   = '0;
                        index_d = (hit_q | match) ? {{(32-TLB_WIDTH){1'b0}}, fidx} : 32'h8000_0000;
                    end
                end
            end
            READ: begin
                stall_o    = 1'b1;
                tlb_addr_o = cp0_index_i[TLB_WIDTH-1:0];
                state_d    = flush_i ? IDLE : RESP;
                entry_d    = flush_i ? entry_q : tlb_rdata_i;
            end
            WRITE: begin
                stall_o     = 1'b1;
                tlb_addr_o  = op_q == 2'd3 ? cp0_random_i[TLB_WIDTH-1:0] : cp0_index_i[TLB_WIDTH-1:0];
                tlb_we_o    = ~flush_i;
                tlb_wdata_o = {cp0_entryhi_i[31:13], 5'b0, cp0_entryhi_i[7:0],
                               cp0_pagemask_i, cp0_entrylo0_i, cp0_entrylo1_i};
                state_d     = flush_i ? IDLE : RESP;
            end
            RESP: begin
                done_o   = ~flush_i;
                tlbcmd_o = flush_i ? 4'b0 : op_q == 2'd0 ? 4'b1000 : op_q == 2'd1 ? 4'b0100 :
                           op_q == 2'd2 ? 4'b0001 : 4'b0010;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= 2'd0;
            cnt_q   <= '0;
            idx_q   <= '0;
            hit_q   <= 1'b0;
            index_q <= 32'd0;
            entry_q <= 128'd0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            hit_q   <= hit_d;
            index_q <= index_d;
            entry_q <= entry_d;
        end
    end
endmodule

// File: tb/tb_tlb_op_ctrl.sv
// tb_tlb_op_ctrl: scoreboard bench for tlb_op_ctrl with a behavioural TLB array.
module tb_tlb_op_ctrl;
    localparam int LINE = 16;
    localparam int W    = 4;
`ifdef TLBP_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         op_valid_i = 1'b0;
    logic [1:0]   op_i = 2'd0;
    logic         flush_i = 1'b0;
    logic         op_ready_o, stall_o, done_o, tlb_we_o;
    logic [31:0]  cp0_index_i = '0, cp0_random_i = '0, cp0_entryhi_i = '0;
    logic [31:0]  cp0_pagemask_i = '0, cp0_entrylo0_i = '0, cp0_entrylo1_i = '0;
    logic [W-1:0] tlb_addr_o;
    logic [127:0] tlb_rdata_i, tlb_wdata_o;
    logic [3:0]   tlbcmd_o;
    logic [31:0]  index_o, entryhi_o, pagemask_o, entrylo0_o, entrylo1_o;

    always #5 clk = ~clk;

    tlb_op_ctrl #(.TLB_LINE(LINE), .TLB_WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .op_valid_i(op_valid_i), .op_i(op_i), .flush_i(flush_i),
        .op_ready_o(op_ready_o), .stall_o(stall_o), .done_o(done_o),
        .cp0_index_i(cp0_index_i), .cp0_random_i(cp0_random_i), .cp0_entryhi_i(cp0_entryhi_i),
        .cp0_pagemask_i(cp0_pagemask_i), .cp0_entrylo0_i(cp0_entrylo0_i), .cp0_entrylo1_i(cp0_entrylo1_i),
        .tlb_addr_o(tlb_addr_o), .tlb_rdata_i(tlb_rdata_i), .tlb_we_o(tlb_we_o), .tlb_wdata_o(tlb_wdata_o),
        .tlbcmd_o(tlbcmd_o), .index_o(index_o), .entryhi_o(entryhi_o), .pagemask_o(pagemask_o),
        .entrylo0_o(entrylo0_o), .entrylo1_o(entrylo1_o)
    );

    logic [127:0] mem [LINE];
    logic         poke_en = 1'b0;
    logic [W-1:0] poke_addr = '0;
    logic [127:0] poke_data = '0;

    always @(posedge clk) begin
        if (tlb_we_o) mem[tlb_addr_o] <= tlb_wdata_o;
        else if (poke_en) mem[poke_addr] <= poke_data;
    end
    assign tlb_rdata_i = mem[tlb_addr_o];

    typedef struct {
        logic [3:0]  cmd;
        int          lat;
        logic [31:0] val;
    } exp_t;
    exp_t sb[$];
    int cmp_n = 0;
    int fail_n = 0;

    function automatic logic [127:0] fill(input int i);
        return {32'hFFF0_00FF + (32'(i) << 13), 96'd0};
    endfunction

    task automatic poke(input int a, input logic [127:0] d);
        @(negedge clk);
        poke_en = 1'b1; poke_addr = W'(a); poke_data = d;
        @(posedge clk);
        #1 poke_en = 1'b0;
    endtask

    task automatic issue(input logic [1:0] op);
        @(negedge clk);
        op_valid_i = 1'b1; op_i = op;
        @(posedge clk);
        #1 op_valid_i = 1'b0;
    endtask

    task automatic wait_done(input int start, output logic ok, output int lat);
        lat = start;
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (done_o) ok = 1'b1;
            else lat++;
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < LINE; i++) poke(i, fill(i));
        @(negedge clk);
        cmp_n++;
        if ({stall_o, done_o, tlb_we_o, tlbcmd_o, tlb_addr_o} !== '0 || tlb_wdata_o !== '0 ||
            {index_o, entryhi_o, pagemask_o, entrylo0_o, entrylo1_o} !== '0) begin
            fail_n++;
            $display("FAIL reset_outputs: got idx=%h hi=%h cmd=%b stall=%b done=%b we=%b", index_o, entryhi_o, tlbcmd_o, stall_o, done_o, tlb_we_o);
        end
        rst_n = 1'b1;
        @(negedge clk);
        cmp_n++;
        if (op_ready_o !== 1'b1) begin fail_n++; $display("FAIL reset_ready: got %b expected 1", op_ready_o); end
    endtask

    task automatic test_tlbwi();
        logic ok; int lat; exp_t e;
        cp0_index_i = 32'hFFFF_FFF5; cp0_entryhi_i = 32'h0040_2011;
        cp0_pagemask_i = 32'h0; cp0_entrylo0_i = 32'h2; cp0_entrylo1_i = 32'h4;
        sb.push_back('{4'b0001, 2, 32'h0});
        issue(2'd2);
        @(negedge clk);
        cmp_n++;
        if ({tlb_we_o, tlb_addr_o} !== {1'b1, 4'd5} || tlb_wdata_o !== {32'h0040_2011, 32'h0, 32'h2, 32'h4}) begin
            fail_n++;
            $display("FAIL wi_write: got we=%b addr=%0d data=%h expected we=1 addr=5", tlb_we_o, tlb_addr_o, tlb_wdata_o);
        end
        wait_done(2, ok, lat);
        e = sb.pop_front();
        cmp_n++;
        if (!ok || lat != e.lat) begin fail_n++; $display("FAIL wi_latency: got %0d (seen=%b) expected %0d", lat, ok, e.lat); end
        cmp_n++;
        if (tlbcmd_o !== e.cmd) begin fail_n++; $display("FAIL wi_cmd: got %b expected %b", tlbcmd_o, e.cmd); end
    endtask

    task automatic test_tlbwr();
        logic ok; int lat; exp_t e;
        cp0_random_i = 32'h0000_0023; cp0_entryhi_i = 32'h0080_1F55;
        cp0_entrylo0_i = 32'h0; cp0_entrylo1_i = 32'h0;
        sb.push_back('{4'b0010, 2, 32'h0});
        issue(2'd3);
        @(negedge clk);
        cmp_n++;
        if ({tlb_we_o, tlb_addr_o} !== {1'b1, 4'd3} || tlb_wdata_o[127:96] !== 32'h0080_0055) begin
            fail_n++;
            $display("FAIL wr_write: got we=%b addr=%0d hi=%h expected we=1 addr=3 hi=00800055", tlb_we_o, tlb_addr_o, tlb_wdata_o[127:96]);
        end
        wait_done(2, ok, lat);
        e = sb.pop_front();
        cmp_n++;
        if (!ok || lat != e.lat) begin fail_n++; $display("FAIL wr_latency: got %0d (seen=%b) expected %0d", lat, ok, e.lat); end
        cmp_n++;
        if (tlbcmd_o !== e.cmd) begin fail_n++; $display("FAIL wr_cmd: got %b expected %b", tlbcmd_o, e.cmd); end
    endtask

    task automatic test_tlbr();
        logic ok; int lat; exp_t e;
        cp0_index_i = 32'd5; cp0_entryhi_i = 32'h0;
        sb.push_back('{4'b0100, 2, 32'h0040_2011});
        @(negedge clk);
        op_valid_i = 1'b1; op_i = 2'd1;
        #1;
        cmp_n++;
        if (stall_o !== 1'b1) begin fail_n++; $display("FAIL r_stall_t0: got %b expected 1", stall_o); end
        @(posedge clk);
        #1 op_valid_i = 1'b0;
        @(negedge clk);
        cmp_n++;
        if (stall_o !== 1'b1) begin fail_n++; $display("FAIL r_stall_t1: got %b expected 1", stall_o); end
        wait_done(2, ok, lat);
        e = sb.pop_front();
        cmp_n++;
        if (!ok || lat != e.lat) begin fail_n++; $display("FAIL r_latency: got %0d (seen=%b) expected %0d", lat, ok, e.lat); end
        cmp_n++;
        if (tlbcmd_o !== e.cmd || stall_o !== 1'b0 || op_ready_o !== 1'b0) begin
            fail_n++; $display("FAIL r_resp: got cmd=%b stall=%b ready=%b expected cmd=%b stall=0 ready=0", tlbcmd_o, stall_o, op_ready_o, e.cmd);
        end
        cmp_n++;
        if (entryhi_o !== e.val || entrylo0_o !== 32'h2 || entrylo1_o !== 32'h4) begin
            fail_n++; $display("FAIL r_data: got hi=%h lo0=%h lo1=%h expected hi=%h lo0=2 lo1=4", entryhi_o, entrylo0_o, entrylo1_o, e.val);
        end
        @(negedge clk);
        cmp_n++;
        if ({done_o, op_ready_o} !== 2'b01) begin fail_n++; $display("FAIL r_after: got done=%b ready=%b expected done=0 ready=1", done_o, op_ready_o); end
    endtask

    task automatic test_tlbp(input string name, input logic [31:0] q, input int lat_exp, input logic [31:0] idx_exp);
        logic ok; int lat; exp_t e;
        cp0_entryhi_i = q;
        sb.push_back('{4'b1000, lat_exp, idx_exp});
        issue(2'd0);
        wait_done(1, ok, lat);
        e = sb.pop_front();
        cmp_n++;
        if (!ok || lat != e.lat) begin fail_n++; $display("FAIL %s_latency: got %0d (seen=%b) expected %0d", name, lat, ok, e.lat); end
        cmp_n++;
        if (tlbcmd_o !== e.cmd || index_o !== e.val) begin
            fail_n++; $display("FAIL %s_result: got cmd=%b index=%h expected cmd=%b index=%h", name, tlbcmd_o, index_o, e.cmd, e.val);
        end
    endtask

    task automatic test_flush();
        cp0_random_i = 32'd6; cp0_entryhi_i = 32'h0123_4077;
        issue(2'd3);
        @(negedge clk);
        flush_i = 1'b1;
        #1;
        cmp_n++;
        if (tlb_we_o !== 1'b0) begin fail_n++; $display("FAIL flush_we: got %b expected 0", tlb_we_o); end
        @(posedge clk);
        #1 flush_i = 1'b0;
        @(negedge clk);
        cmp_n++;
        if ({done_o, tlbcmd_o, op_ready_o} !== 6'b0_0000_1) begin
            fail_n++; $display("FAIL flush_state: got done=%b cmd=%b ready=%b expected done=0 cmd=0000 ready=1", done_o, tlbcmd_o, op_ready_o);
        end
        cmp_n++;
        if (mem[6] !== fill(6)) begin fail_n++; $display("FAIL flush_array: got %h expected %h", mem[6], fill(6)); end
    endtask

    task automatic test_reset_probe();
        cp0_entryhi_i = 32'h1234_6022;
        issue(2'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        cmp_n++;
        if ({stall_o, done_o, tlb_we_o, tlbcmd_o, tlb_addr_o} !== '0 || tlb_wdata_o !== '0 ||
            {index_o, entryhi_o, pagemask_o, entrylo0_o, entrylo1_o} !== '0 || op_ready_o !== 1'b1) begin
            fail_n++;
            $display("FAIL rst_probe: got idx=%h hi=%h cmd=%b stall=%b ready=%b addr=%0d", index_o, entryhi_o, tlbcmd_o, stall_o, op_ready_o, tlb_addr_o);
        end
    endtask

    initial begin
        test_reset();
        test_tlbwi();
        test_tlbwr();
        test_tlbr();
        poke(9, {32'h0040_2011, 32'h0, 32'h1, 32'h1});
        test_tlbp("p_global", 32'h0040_2022, EARLY ? 11 : 17, 32'h0000_0009);
        test_tlbp("p_miss", 32'h1234_6022, 17, 32'h8000_0000);
        poke(3, {32'h0ABC_E033, 96'd0});
        poke(7, {32'h0ABC_E033, 96'd0});
        test_tlbp("p_multi", 32'h0ABC_E033, EARLY ? 5 : 17, 32'h0000_0003);
        poke(2, {32'h0060_0044, 32'h0000_6000, 64'd0});
        test_tlbp("p_mask", 32'h0060_2044, EARLY ? 4 : 17, 32'h0000_0002);
        test_flush();
        test_reset_probe();
        test_tlbp("p_after_rst", 32'h0040_2022, EARLY ? 11 : 17, 32'h0000_0009);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, fail_n);
        $finish;
    end
endmodule
